gate_sequencer: RTL and testbench

//  Sequences a program of gates through the combinational gate-state multiplier
//  (real-only, Q2.14). Owns the state-vector register, fetches one gate matrix at
//  a time from an external gate store, drives the multiplier, waits for it to

---
 rtl/gate_sequencer.sv | 157 +++++++++++++++
 tb/tb_gate_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sequencer.sv
// Gate program sequencer: fetches gate matrices one at a time, drives an external
// combinational gate-state multiplier and captures its result as the new state.
// Flat layout: amplitude i at [i*WIDTH +: WIDTH], matrix element [r][c] at [(r*2**N+c)*WIDTH +: WIDTH].
module gate_sequencer #(
  parameter int N         = 2,
  parameter int WIDTH     = 16,
  parameter int MAX_GATES = 16,
  parameter int SETTLE    = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 st_wr_en,
  input  logic [N-1:0]                         st_wr_addr,
  input  logic [WIDTH-1:0]                     st_wr_data,
  input  logic [$clog2(MAX_GATES+1)-1:0]       num_gates,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 gate_req,
  output logic [$clog2(MAX_GATES)-1:0]         gate_idx,
  input  logic                                 gate_ack,
  input  logic [WIDTH*(2**N)*(2**N)-1:0]       gate_in,
  output logic [WIDTH*(2**N)*(2**N)-1:0]       mult_gate,
  output logic [WIDTH*(2**N)-1:0]              mult_state,
  input  logic [WIDTH*(2**N)-1:0]              mult_out,
  output logic [WIDTH*(2**N)-1:0]              state_out,
  output logic                                 busy,
  output logic                                 done
);
  localparam int DIM = 2**N;
  localparam int SW  = WIDTH*DIM;
  localparam int MW  = WIDTH*DIM*DIM;
  localparam int GW  = $clog2(MAX_GATES+1);
  localparam int KW  = $clog2(MAX_GATES);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE+1) : 1;

  localparam logic [GW-1:0]    MAX_G     = GW'(MAX_GATES);
  localparam logic [GW-1:0]    G_ZERO    = {GW{1'b0}};
  localparam logic [GW-1:0]    G_ONE     = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]    K_ZERO    = {KW{1'b0}};
  localparam logic [KW-1:0]    K_ONE     = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    C_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    C_SETTLE  = CW'(SETTLE);
  localparam logic [WIDTH-1:0] AMP_ONE   = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [SW-1:0]    RST_STATE = {{(SW-WIDTH){1'b0}}, AMP_ONE};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [SW-1:0] st_q, st_d;
  logic [MW-1:0] gate_q, gate_d;
  logic [KW-1:0] k_q, k_d;
  logic [GW-1:0] g_q, g_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and datapath updates; abort outranks every other transition.
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    gate_d = gate_q;
    k_d    = k_q;
    g_d    = g_q;
    cnt_d  = cnt_q;
    if (abort && (fsm_q != ST_IDLE)) begin
      fsm_d = ST_IDLE;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (st_wr_en) begin
            st_d[st_wr_addr*WIDTH +: WIDTH] = st_wr_data;
          end else begin
            st_d = st_q;
          end
          if (start) begin
            g_d   = (num_gates > MAX_G) ? MAX_G : num_gates;
            k_d   = K_ZERO;
            fsm_d = (g_d == G_ZERO) ? ST_DONE : ST_FETCH;
          end else begin
            fsm_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (gate_ack) begin
            gate_d = gate_in;
            cnt_d  = C_SETTLE;
            fsm_d  = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
          end else begin
            fsm_d = ST_FETCH;
          end
        end
        ST_SETTLE: begin
          if (cnt_q <= C_ONE) begin
            fsm_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
        ST_CAPTURE: begin
          st_d = mult_out;
          if ((GW'(k_q) + G_ONE) == g_q) begin
            fsm_d = ST_DONE;
          end else begin
            k_d   = k_q + K_ONE;
            fsm_d = ST_FETCH;
          end
        end
        ST_DONE: fsm_d = ST_IDLE;
        default: fsm_d = ST_IDLE;
      endcase
    end
    req_d  = (fsm_d == ST_FETCH);
    busy_d = (fsm_d != ST_IDLE);
    done_d = (fsm_d == ST_DONE);
  end

  // State register, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= ST_IDLE;
      st_q   <= RST_STATE;
      gate_q <= {MW{1'b0}};
      k_q    <= K_ZERO;
      g_q    <= G_ZERO;
      cnt_q  <= {CW{1'b0}};
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      gate_q <= gate_d;
      k_q    <= k_d;
      g_q    <= g_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign gate_req   = req_q;
  assign gate_idx   = k_q;
  assign mult_gate  = gate_q;
  assign mult_state = st_q;
  assign state_out  = st_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Scoreboard bench for gate_sequencer: a behavioural matrix-vector model predicts the
// final state and done cycle of each program; a monitor pops and compares on done.
module tb_gate_sequencer;
  localparam int N         = 2;
  localparam int WIDTH     = 16;
  localparam int MAX_GATES = 16;
  localparam int SETTLE    = 1;
  localparam int DIM       = 1 << N;
  localparam int SW        = DIM*WIDTH;
  localparam int MW        = DIM*DIM*WIDTH;
  localparam logic [SW-1:0] RST_ST = 64'h0000_0000_0000_4000;

  logic            clk = 1'b0;
  logic            reset;
  logic            st_wr_en;
  logic [N-1:0]    st_wr_addr;
  logic [WIDTH-1:0] st_wr_data;
  logic [4:0]      num_gates;
  logic            start;
  logic            abort;
  logic            gate_req;
  logic [3:0]      gate_idx;
  logic            gate_ack;
  logic [MW-1:0]   gate_in;
  logic [MW-1:0]   mult_gate;
  logic [SW-1:0]   mult_state;
  logic [SW-1:0]   mult_out;
  logic [SW-1:0]   state_out;
  logic            busy;
  logic            done;

  typedef struct { logic [SW-1:0] st; int edge_n; } exp_t;
  exp_t          sbq[$];
  int            fetch_log[$];
  logic [MW-1:0] prog [MAX_GATES];
  logic [SW-1:0] model_st;
  logic [SW-1:0] mid_exp;
  bit            mid_chk = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            edges = 0;
  int            ack_delay = 0;
  int            cur_g = 0;

  gate_sequencer #(.N(N), .WIDTH(WIDTH), .MAX_GATES(MAX_GATES), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr),
    .st_wr_data(st_wr_data), .num_gates(num_gates), .start(start), .abort(abort),
    .gate_req(gate_req), .gate_idx(gate_idx), .gate_ack(gate_ack), .gate_in(gate_in),
    .mult_gate(mult_gate), .mult_state(mult_state), .mult_out(mult_out),
    .state_out(state_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // Real-valued Q2.14 matrix times vector; serves as the multiplier and as the model.
  function automatic logic [SW-1:0] mat_vec(input logic [MW-1:0] g, input logic [SW-1:0] s);
    logic [SW-1:0] r;
    longint acc;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      acc = 0;
      for (int j = 0; j < DIM; j++)
        acc += longint'($signed(g[(i*DIM+j)*WIDTH +: WIDTH])) * longint'($signed(s[j*WIDTH +: WIDTH]));
      r[i*WIDTH +: WIDTH] = WIDTH'(acc >>> 14);
    end
    return r;
  endfunction

  assign mult_out = mat_vec(mult_gate, mult_state);

  function automatic logic [MW-1:0] perm(input int p0, input int p1, input int p2, input int p3);
    logic [MW-1:0] m;
    int p[4];
    p = '{p0, p1, p2, p3};
    m = '0;
    for (int r = 0; r < DIM; r++) m[(r*DIM+p[r])*WIDTH +: WIDTH] = 16'h4000;
    return m;
  endfunction

  function automatic logic [MW-1:0] hadamard(input int q);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (((r ^ c) & ~(1 << q)) == 0)
          m[(r*DIM+c)*WIDTH +: WIDTH] = (((r >> q) & (c >> q) & 1) != 0) ? 16'hD2BF : 16'h2D41;
    return m;
  endfunction

  function automatic logic [MW-1:0] pick(input int k);
    logic [MW-1:0] m;
    case (k)
      0:       m = perm(1, 0, 3, 2);
      1:       m = perm(2, 3, 0, 1);
      2:       m = hadamard(0);
      3:       m = hadamard(1);
      4:       m = perm(0, 3, 2, 1);
      default: begin
        m = '0;
        for (int e = 0; e < DIM*DIM; e++) m[e*WIDTH +: WIDTH] = 16'($urandom);
      end
    endcase
    return m;
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at edge %0d", edges);
        end else begin
          e = sbq.pop_front();
          chk("final_state", MW'(state_out), MW'(e.st));
          chk("done_edge", MW'(edges), MW'(e.edge_n));
        end
      end
    end
  end

  // Gate store: answers gate_req after ack_delay waiting cycles.
  initial begin
    int wait_cnt;
    int held_idx;
    gate_ack = 1'b0;
    gate_in  = '0;
    wait_cnt = 0;
    held_idx = 0;
    forever begin
      @(negedge clk);
      gate_ack = 1'b0;
      if (gate_req) begin
        if (wait_cnt == 0) held_idx = int'(gate_idx);
        else chk("idx_stable", MW'(gate_idx), MW'(held_idx));
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          if (mid_chk && gate_idx == 4'd1) chk("mid_state", MW'(state_out), MW'(mid_exp));
          gate_ack = 1'b1;
          gate_in  = prog[gate_idx];
          fetch_log.push_back(int'(gate_idx));
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic wr(input int addr, input logic [WIDTH-1:0] val);
    @(negedge clk);
    st_wr_en = 1'b1; st_wr_addr = N'(addr); st_wr_data = val;
    @(negedge clk);
    st_wr_en = 1'b0;
    model_st[addr*WIDTH +: WIDTH] = val;
  endtask

  task automatic begin_prog(input int ng, input int d, input bit push);
    exp_t e;
    logic [SW-1:0] s;
    cur_g = (ng > MAX_GATES) ? MAX_GATES : ng;
    s = model_st;
    for (int i = 0; i < cur_g; i++) s = mat_vec(prog[i], s);
    ack_delay = d;
    fetch_log.delete();
    @(negedge clk);
    num_gates = 5'(ng);
    start = 1'b1;
    e.st = s;
    e.edge_n = edges + 1 + cur_g*(SETTLE + 2 + d);
    if (push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_prog();
    int n;
    logic [SW-1:0] s;
    bit ord_ok;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL timeout busy=%0b pending=%0d", busy, sbq.size());
      sbq.delete();
    end
    s = model_st;
    for (int i = 0; i < cur_g; i++) s = mat_vec(prog[i], s);
    model_st = s;
    chk("fetch_count", MW'(fetch_log.size()), MW'(cur_g));
    ord_ok = 1'b1;
    for (int i = 0; i < fetch_log.size(); i++) if (fetch_log[i] != i) ord_ok = 1'b0;
    chk("fetch_order", MW'(ord_ok), MW'(1));
  endtask

  task automatic run_prog(input int ng, input int d);
    begin_prog(ng, d, 1'b1);
    finish_prog();
  endtask

  initial begin
    bit near;
    int a;
    reset = 1'b0; st_wr_en = 1'b0; st_wr_addr = '0; st_wr_data = '0;
    num_gates = '0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < MAX_GATES; i++) prog[i] = '0;
    model_st = RST_ST;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_state", MW'(state_out), MW'(RST_ST));
    chk("rst_busy", MW'(busy), MW'(0));
    chk("rst_done", MW'(done), MW'(0));
    chk("rst_req", MW'(gate_req), MW'(0));
    chk("rst_idx", MW'(gate_idx), MW'(0));
    chk("rst_mgate", mult_gate, '0);

    prog[0] = perm(1, 0, 3, 2);
    run_prog(1, 0);
    chk("x_state", MW'(state_out), MW'(64'h0000_0000_4000_0000));

    wr(0, 16'h4000);
    wr(1, 16'h0000);
    prog[0] = hadamard(0);
    prog[1] = hadamard(0);
    mid_exp = 64'h0000_0000_2D41_2D41;
    mid_chk = 1'b1;
    run_prog(2, 0);
    mid_chk = 1'b0;
    near = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      a = int'($signed(state_out[i*WIDTH +: WIDTH])) - ((i == 0) ? 16384 : 0);
      if (a > 2 || a < -2) near = 1'b0;
    end
    chk("hh_near_identity", MW'(near), MW'(1));

    run_prog(0, 0);
    for (int i = 0; i < MAX_GATES; i++) prog[i] = pick(int'($urandom_range(0, 4)));
    run_prog(20, 0);

    prog[0] = perm(2, 3, 0, 1);
    run_prog(1, 5);

    begin_prog(3, 100, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_req_before", MW'(gate_req), MW'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", MW'(busy), MW'(0));
    chk("abort_req", MW'(gate_req), MW'(0));
    chk("abort_state", MW'(state_out), MW'(model_st));
    repeat (4) @(negedge clk);

    wr(3, 16'h1234);
    prog[0] = perm(1, 0, 3, 2);
    prog[1] = hadamard(1);
    begin_prog(2, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_state", MW'(state_out), MW'(RST_ST));
    chk("midrst_busy", MW'(busy), MW'(0));
    chk("midrst_req", MW'(gate_req), MW'(0));
    chk("midrst_mgate", mult_gate, '0);
    @(negedge clk);
    reset = 1'b1;
    model_st = RST_ST;
    @(negedge clk);

    prog[0] = hadamard(0);
    prog[1] = perm(0, 3, 2, 1);
    begin_prog(2, 4, 1'b1);
    @(negedge clk);
    start = 1'b1; num_gates = 5'd1;
    st_wr_en = 1'b1; st_wr_addr = 2'd2; st_wr_data = 16'h1234;
    @(negedge clk);
    start = 1'b0; st_wr_en = 1'b0;
    finish_prog();

    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 2; w++) wr(int'($urandom_range(0, 3)), 16'($urandom));
      for (int i = 0; i < MAX_GATES; i++) prog[i] = pick(int'($urandom_range(0, 5)));
      run_prog(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
